// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-granular memory port between an I-cache and
// a D-cache. Round-robin on ties, one transaction in flight, at least one
// idle cycle between transactions, and a one-cycle mask that stops a stale
// request from being re-granted right after its own response.
//
// Handshake semantics (all three sides): a requester raises x_pmem_read
// (or d_pmem_write) with a stable line address and holds it until it sees
// x_pmem_resp for one cycle; the arbiter raises mem_read or mem_write and
// holds it, with address/data constant, until memory answers with a
// one-cycle mem_resp, which is forwarded combinationally to the owner in
// that same cycle together with mem_rdata.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // All control state lives in one struct so a checker can bind to ctrl_q
  // and see the FSM state, the round-robin pointer and the stale masks.
  typedef struct packed {
    state_e state;
    logic   last_grant;
    logic   mask_i;
    logic   mask_d;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    state:      ST_IDLE,
    last_grant: GRANT_I,
    mask_i:     1'b0,
    mask_d:     1'b0
  };

  ctrl_t         ctrl_q, ctrl_d;
  logic [31:0]   addr_q, addr_d;
  logic [255:0]  wdata_q, wdata_d;
  logic          op_write_q, op_write_d;

  logic          req_i;
  logic          req_d;
  logic          serving;

  // Effective requests: a requester just answered is ignored for one cycle.
  always_comb begin
    req_i = i_pmem_read & ~ctrl_q.mask_i;
    req_d = (d_pmem_read | d_pmem_write) & ~ctrl_q.mask_d;
  end

  // State register and latched transaction; reset aborts anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q     <= CTRL_RESET;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
    end
  end

  // Next-state: grant from IDLE, complete on mem_resp, arm the one-cycle mask.
  always_comb begin
    ctrl_d        = ctrl_q;
    ctrl_d.mask_i = 1'b0;
    ctrl_d.mask_d = 1'b0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    op_write_d    = op_write_q;
    case (ctrl_q.state)
      ST_IDLE: begin
        // D wins when alone, or on a tie when I had the previous grant.
        if (req_d && (!req_i || (ctrl_q.last_grant == GRANT_I))) begin
          ctrl_d.state = ST_SERVE_D;
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
          // A simultaneous read+write is treated as the writeback.
          op_write_d   = d_pmem_write;
        end else if (req_i) begin
          ctrl_d.state = ST_SERVE_I;
          addr_d       = i_pmem_address;
          wdata_d      = '0;
          op_write_d   = 1'b0;
        end
      end
      ST_SERVE_I: begin
        if (mem_resp) begin
          ctrl_d.state      = ST_IDLE;
          ctrl_d.last_grant = GRANT_I;
          ctrl_d.mask_i     = 1'b1;
        end
      end
      ST_SERVE_D: begin
        if (mem_resp) begin
          ctrl_d.state      = ST_IDLE;
          ctrl_d.last_grant = GRANT_D;
          ctrl_d.mask_d     = 1'b1;
        end
      end
      default: begin
        ctrl_d.state = ST_IDLE;
      end
    endcase
  end

  // Outputs: strobes only from latched copies, responses only to the owner,
  // everything forced low while reset is held.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    serving      = rst && ((ctrl_q.state == ST_SERVE_I) || (ctrl_q.state == ST_SERVE_D));
    if (serving) begin
      mem_read    = ~op_write_q;
      mem_write   = op_write_q;
      mem_address = addr_q;
      mem_wdata   = wdata_q;
      if (mem_resp) begin
        if (ctrl_q.state == ST_SERVE_I) begin
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = mem_rdata;
        end else begin
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus a randomized phase. Stimulus
// pushes expected memory transactions (in the order the arbitration rules
// dictate) onto exp_q; a memory model pops and checks them as strobes appear
// and pushes the expected response onto exp_resp_q; a response monitor pops
// and checks what the caches receive.
module tb_cache_arbiter;

  localparam int  MW    = 290;   // {owner, write, addr[31:0], wdata[255:0]}
  localparam int  RW    = 257;   // {owner, rdata[255:0]}
  localparam bit  OWN_I = 1'b0;
  localparam bit  OWN_D = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int checks   = 0;
  int failures = 0;

  logic [MW-1:0] exp_q[$];
  logic [RW-1:0] exp_resp_q[$];

  int lat_fixed  = 0;      // 0 = random memory latency 1..4
  bit force_resp = 1'b0;   // drive mem_resp while no strobe is up
  bit resp_due   = 1'b0;   // memory model is answering this cycle
  bit last_owner = OWN_I;  // owner of the last completed transaction

  cache_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    return a & 32'hFFFF_FFE0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit owner, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [255:0] wd);
    if (owner == OWN_I) begin
      i_pmem_read    = rd;
      i_pmem_address = addr;
    end else begin
      d_pmem_read    = rd;
      d_pmem_write   = wr;
      d_pmem_address = addr;
      d_pmem_wdata   = wd;
    end
  endtask

  task automatic drop(input bit owner);
    if (owner == OWN_I) i_pmem_read = 1'b0;
    else begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  task automatic push_exp(input bit owner, input bit wr,
                          input logic [31:0] addr, input logic [255:0] wd);
    exp_q.push_back({owner, wr, addr, wd});
  endtask

  task automatic wait_resp(input bit owner);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (owner == OWN_I) ? (i_pmem_resp === 1'b1) : (d_pmem_resp === 1'b1);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL resp_timeout owner=%0d got no response within 40 cycles", owner);
    end
  endtask

  task automatic check_strobe(input string name, input logic exp_rd, input logic exp_wr);
    checks++;
    if (mem_read !== exp_rd || mem_write !== exp_wr) begin
      failures++;
      $display("FAIL %s mem_read=%b mem_write=%b expected %b %b", name, mem_read, mem_write, exp_rd, exp_wr);
    end
  endtask

  task automatic check_addr(input string name, input logic [31:0] exp_a);
    checks++;
    if (mem_address !== exp_a) begin
      failures++;
      $display("FAIL %s mem_address=%h expected %h", name, mem_address, exp_a);
    end
  endtask

  task automatic check_resp_bits(input string name, input logic exp_i, input logic exp_d);
    checks++;
    if (i_pmem_resp !== exp_i || d_pmem_resp !== exp_d) begin
      failures++;
      $display("FAIL %s i_pmem_resp=%b d_pmem_resp=%b expected %b %b", name, i_pmem_resp, d_pmem_resp, exp_i, exp_d);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
         mem_read, mem_write, mem_address, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL %s outputs not all zero: mem_read=%b mem_write=%b addr=%h i_resp=%b d_resp=%b",
               name, mem_read, mem_write, mem_address, i_pmem_resp, d_pmem_resp);
    end
  endtask

  // ---------------- memory model + memory-side checker ----------------
  initial begin : mem_model
    int cnt;
    int cur_lat;
    logic [MW-1:0] cur;
    logic [255:0] rd;
    cnt       = 0;
    cur_lat   = 1;
    cur       = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      resp_due = 1'b0;
      rd = rand256();
      if (mem_read || mem_write) begin
        cnt++;
        checks++;
        if (cnt == 1) begin
          cur_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL mem_txn unexpected transaction addr=%h rd=%b wr=%b", mem_address, mem_read, mem_write);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            if (mem_write !== cur[288] || mem_read !== ~cur[288] || mem_address !== cur[287:256] ||
                (cur[288] && mem_wdata !== cur[255:0])) begin
              failures++;
              $display("FAIL mem_txn addr=%h rd=%b wr=%b expected addr=%h wr=%b owner=%0d",
                       mem_address, mem_read, mem_write, cur[287:256], cur[288], cur[289]);
            end
          end
        end else begin
          if (mem_address !== cur[287:256] || mem_write !== cur[288] || mem_read !== ~cur[288]) begin
            failures++;
            $display("FAIL mem_hold addr=%h rd=%b wr=%b expected addr=%h wr=%b",
                     mem_address, mem_read, mem_write, cur[287:256], cur[288]);
          end
        end
        if (cnt == cur_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = rd;
          resp_due  = 1'b1;
          exp_resp_q.push_back({cur[289], rd});
        end else begin
          mem_resp  = 1'b0;
          mem_rdata = rd;
        end
      end else begin
        cnt       = 0;
        mem_resp  = force_resp;
        mem_rdata = rd;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : resp_mon
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      checks++;
      if (resp_due) begin
        if (exp_resp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_scoreboard no expected response queued");
        end else begin
          e = exp_resp_q.pop_front();
          if (e[256] == OWN_I) begin
            if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0 || i_pmem_rdata !== e[255:0] || d_pmem_rdata !== '0) begin
              failures++;
              $display("FAIL resp_i i_resp=%b d_resp=%b i_rdata=%h expected %h", i_pmem_resp, d_pmem_resp, i_pmem_rdata, e[255:0]);
            end
          end else begin
            if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0 || d_pmem_rdata !== e[255:0] || i_pmem_rdata !== '0) begin
              failures++;
              $display("FAIL resp_d i_resp=%b d_resp=%b d_rdata=%h expected %h", i_pmem_resp, d_pmem_resp, d_pmem_rdata, e[255:0]);
            end
          end
        end
      end else begin
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
          failures++;
          $display("FAIL resp_quiet i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h", i_pmem_resp, d_pmem_resp, i_pmem_rdata, d_pmem_rdata);
        end
      end
    end
  end

  // ---------------- scenario drivers ----------------
  task automatic do_single(input bit owner);
    logic [31:0]  a;
    logic [255:0] w;
    bit rd, wr;
    a  = rand_addr();
    w  = rand256();
    rd = 1'b1;
    wr = 1'b0;
    if (owner == OWN_D) begin
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
    end
    step();
    drive_req(owner, rd, wr, a, w);
    push_exp(owner, wr, a, w);
    wait_resp(owner);
    step();
    drop(owner);
    last_owner = owner;
  endtask

  task automatic do_pair();
    bit first, second, d_rd, d_wr;
    logic [31:0]  a_i, a_d;
    logic [255:0] w_d;
    first  = ~last_owner;
    second = last_owner;
    a_i = rand_addr();
    a_d = rand_addr();
    w_d = rand256();
    d_wr = $urandom_range(0, 1);
    d_rd = d_wr ? $urandom_range(0, 1) : 1'b1;
    if (first == OWN_D) begin
      push_exp(OWN_D, d_wr, a_d, w_d);
      push_exp(OWN_I, 1'b0, a_i, '0);
    end else begin
      push_exp(OWN_I, 1'b0, a_i, '0);
      push_exp(OWN_D, d_wr, a_d, w_d);
    end
    step();
    drive_req(OWN_I, 1'b1, 1'b0, a_i, '0);
    drive_req(OWN_D, d_rd, d_wr, a_d, w_d);
    wait_resp(first);
    step();
    drop(first);
    wait_resp(second);
    step();
    drop(second);
    last_owner = second;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0]  a_i, a_d;
    logic [255:0] w_d;
    bit           own[4];
    bit           wr[4];
    logic [31:0]  adr[4];
    logic [255:0] wd[4];

    rst            = 1'b0;
    force_resp     = 1'b1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0040;
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0080;
    d_pmem_wdata   = rand256();

    // Reset held with requests and mem_resp active: everything stays low.
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset_outputs");
    end
    step();
    drop(OWN_I);
    drop(OWN_D);
    force_resp = 1'b0;

    // Both requesters in the first cycle after reset: D (writeback) first.
    lat_fixed = 2;
    a_i = rand_addr();
    a_d = rand_addr();
    w_d = rand256();
    push_exp(OWN_D, 1'b1, a_d, w_d);
    push_exp(OWN_I, 1'b0, a_i, '0);
    step();
    rst = 1'b1;
    drive_req(OWN_I, 1'b1, 1'b0, a_i, '0);
    drive_req(OWN_D, 1'b1, 1'b1, a_d, w_d);
    @(negedge clk);
    check_strobe("tie_grant_latency", 1'b0, 1'b0);
    @(negedge clk);
    check_strobe("tie_d_first_write", 1'b0, 1'b1);
    check_addr("tie_d_addr", a_d);
    wait_resp(OWN_D);
    step();
    drop(OWN_D);
    @(negedge clk);
    check_strobe("tie_idle_gap", 1'b0, 1'b0);
    @(negedge clk);
    check_strobe("tie_i_second", 1'b1, 1'b0);
    check_addr("tie_i_addr", a_i);
    wait_resp(OWN_I);
    step();
    drop(OWN_I);
    last_owner = OWN_I;

    // I-only read at 0x60, memory answers on the third strobe cycle.
    lat_fixed = 3;
    step();
    drive_req(OWN_I, 1'b1, 1'b0, 32'h0000_0060, '0);
    push_exp(OWN_I, 1'b0, 32'h0000_0060, '0);
    @(negedge clk);
    check_strobe("i_only_latency", 1'b0, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check_strobe("i_only_strobe", 1'b1, 1'b0);
      check_addr("i_only_addr", 32'h0000_0060);
      check_resp_bits("i_only_resp", (j == 3), 1'b0);
    end
    step();
    drop(OWN_I);
    @(negedge clk);
    check_strobe("i_only_done", 1'b0, 1'b0);
    check_resp_bits("i_only_resp_done", 1'b0, 1'b0);
    last_owner = OWN_I;

    // Stale I request left high after its response: masked one cycle only.
    lat_fixed = 2;
    a_i = rand_addr();
    push_exp(OWN_I, 1'b0, a_i, '0);
    push_exp(OWN_I, 1'b0, a_i, '0);
    step();
    drive_req(OWN_I, 1'b1, 1'b0, a_i, '0);
    wait_resp(OWN_I);
    @(negedge clk);
    check_strobe("stale_masked_cycle", 1'b0, 1'b0);
    @(negedge clk);
    check_strobe("stale_grant_cycle", 1'b0, 1'b0);
    @(negedge clk);
    check_strobe("stale_regrant", 1'b1, 1'b0);
    wait_resp(OWN_I);
    step();
    drop(OWN_I);
    last_owner = OWN_I;

    // D writeback at 0x1000; requester address moves to 0x2000 mid-flight.
    lat_fixed = 4;
    w_d = rand256();
    push_exp(OWN_D, 1'b1, 32'h0000_1000, w_d);
    step();
    drive_req(OWN_D, 1'b0, 1'b1, 32'h0000_1000, w_d);
    @(negedge clk);
    step();
    d_pmem_address = 32'h0000_2000;
    d_pmem_wdata   = rand256();
    @(negedge clk);
    check_addr("wb_addr_held", 32'h0000_1000);
    wait_resp(OWN_D);
    step();
    drop(OWN_D);
    last_owner = OWN_D;

    // mem_resp while IDLE is ignored.
    step();
    force_resp = 1'b1;
    @(negedge clk);
    check_resp_bits("idle_mem_resp", 1'b0, 1'b0);
    check_strobe("idle_mem_resp_strobe", 1'b0, 1'b0);
    step();
    force_resp = 1'b0;
    @(negedge clk);
    check_strobe("idle_mem_resp_after", 1'b0, 1'b0);

    // Reset in the middle of SERVE_I, then a fresh I transaction.
    lat_fixed = 6;
    a_i = rand_addr();
    push_exp(OWN_I, 1'b0, a_i, '0);
    step();
    drive_req(OWN_I, 1'b1, 1'b0, a_i, '0);
    @(negedge clk);
    @(negedge clk);
    check_strobe("rst_serve_active", 1'b1, 1'b0);
    step();
    rst = 1'b0;
    drop(OWN_I);
    @(negedge clk);
    check_all_zero("rst_in_serve");
    step();
    @(negedge clk);
    check_all_zero("rst_after_edge");
    step();
    rst = 1'b1;
    lat_fixed = 0;
    last_owner = OWN_I;
    do_single(OWN_I);

    // Both held high for four transactions: D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      own[k] = (k % 2 == 0) ? OWN_D : OWN_I;
      adr[k] = rand_addr();
      wd[k]  = rand256();
      wr[k]  = (own[k] == OWN_D) ? 1'($urandom_range(0, 1)) : 1'b0;
      push_exp(own[k], wr[k], adr[k], wd[k]);
    end
    step();
    drive_req(own[0], ~wr[0], wr[0], adr[0], wd[0]);
    drive_req(own[1], ~wr[1], wr[1], adr[1], wd[1]);
    for (int k = 0; k < 4; k++) begin
      wait_resp(own[k]);
      step();
      if (k + 2 < 4) drive_req(own[k+2], ~wr[k+2], wr[k+2], adr[k+2], wd[k+2]);
      else drop(own[k]);
    end
    last_owner = OWN_I;

    // Randomized mix of single and contended transactions.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0:       do_single(OWN_I);
        1:       do_single(OWN_D);
        default: do_pair();
      endcase
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mem_queue_drain %0d transactions never appeared, expected 0", exp_q.size());
    end
    checks++;
    if (exp_resp_q.size() != 0) begin
      failures++;
      $display("FAIL resp_queue_drain %0d responses never delivered, expected 0", exp_resp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
